aes_sbox_rom_seq: RTL and testbench
===================================

// Module: aes_sbox_rom_seq
// PURPOSE
//  Parametrised AES byte-substitution engine over an external S-box ROM.
//  Holds the forward and inverse tables in one 512x8 ROM, selected by a per-word mode bit.
//  Takes NBYTES-wide words over a valid/ready handshake and issues one ROM address per cycle.
//  Tolerates ROM read latency of ROM_LAT cycles. Returns the substituted word with output backpressure.
//  Sits between the round datapath (SubBytes/InvSubBytes, key expansion) and the ROM pins.
// PARAMETERS
//  NBYTES   4  bytes per word, legal 1..16; word width W = 8*NBYTES
//  ROM_LAT  1  edges from rom_addr update to rom_data capture, legal 1..4
// PORTS
//  clk        in   1   clock, rising edge
//  rst_n      in   1   asynchronous reset, active-low
//  flush      in   1   sync abort: drop the word in flight, return to IDLE
//  in_valid   in   1   in_data/in_inv valid
//  in_ready   out  1   = (state==IDLE) & ~flush, combinational
//  in_data    in   W   bytes to substitute; MS byte is processed first
//  in_inv     in   1   0 = forward S-box, 1 = inverse S-box
//  out_valid  out  1   out_data valid, held until out_ready
//  out_ready  in   1   consumer accepts out_data
//  out_data   out  W   substituted word, byte positions preserved
//  busy       out  1   state != IDLE
//  rom_addr   out  9   {inv, byte}, registered
//  rom_data   in   8   ROM output
//  rom_ce_n   out  1   ROM chip enable, active-low, registered
//  rom_oe_n   out  1   ROM output enable, active-low; always equals rom_ce_n
// BEHAVIOUR
//  Reset values: out_data=0, out_valid=0, rom_addr=0, rom_ce_n=1, rom_oe_n=1, busy=0, state=IDLE.
//  States: IDLE -> RUN -> DONE -> IDLE.
//  IDLE
//   - Accept at edge A when in_valid & in_ready.
//   - At A: latch in_data and in_inv; rom_addr <= {in_inv, byte NBYTES-1}; rom_ce_n/oe_n <= 0; go to RUN.
//  RUN
//   - Issue: edges A+1..A+NBYTES-1 drive the next lower byte address, one per edge.
//     Hold rom_addr unchanged once all NBYTES are issued.
//   - Capture: byte k is captured from rom_data at edge (issue edge of k) + ROM_LAT.
//     Captures need a ROM_LAT-deep tag pipeline; issue and capture overlap.
//   - Last capture is at edge A+NBYTES+ROM_LAT-1. At that same edge:
//     out_valid <= 1, rom_ce_n/oe_n <= 1, go to DONE.
//   - Latency from accept to out_valid: NBYTES+ROM_LAT-1 edges (4 for defaults).
//  DONE
//   - out_data is stable while out_valid=1.
//   - On out_valid & out_ready: out_valid <= 0, go to IDLE. in_ready is first high the cycle after.
//   - No new word is accepted in the same cycle as the output handshake.
//  out_data bytes not yet captured keep their previous value; only out_valid qualifies out_data.
//  flush (any state): at the next edge go to IDLE, out_valid <= 0, rom_ce_n/oe_n <= 1.
//   - Pending captures are discarded; out_data is retained.
//   - flush & in_valid together: flush wins, nothing is accepted.
//  rst_n low mid-operation: all outputs return to reset values immediately (async); the word is lost.
//  Mode is sampled only at accept; a change of in_inv during RUN has no effect.
//  NBYTES=1: single issue edge; for ROM_LAT=1, out_valid rises at edge A+1.
//  The ROM model returns fwd S-box[a[7:0]] when a[8]=0 and inv S-box[a[7:0]] when a[8]=1.
// TESTING
//  T1 defaults, in_inv=0, in_data=32'h0001_53FF
//     -> out_data=32'h637C_ED16; out_valid at A+4; rom_ce_n low for exactly 4 cycles.
//  T2 defaults, in_inv=1, in_data=32'h637C_ED16
//     -> out_data=32'h0001_53FF; rom_addr[8]=1 on all 4 issues.
//  T3 ROM_LAT=3, T1 stimulus -> same out_data, out_valid at A+6, ce_n low 6 cycles.
//  T4 out_ready low 5 cycles after out_valid, in_valid held high with a second word
//     -> out_data stable; in_ready=0 until the cycle after the handshake; second word then accepted.
//  T5 flush at A+2
//     -> out_valid never rises; ce_n=1 and in_ready=1 next cycle.
//     Repeat with rst_n pulse at A+2 -> all outputs at reset values.
//  T6 NBYTES=16, ROM_LAT=2: forward then inverse of a random 128-bit word -> original word returned.
//     Out latency 17 edges each pass.

Source files
------------

// File: rtl/aes_sbox_rom_seq.sv
// AES byte-substitution sequencer: walks a word MS byte first through an external
// 512x8 S-box ROM (forward half at 0x000, inverse half at 0x100) and returns the substituted word.
//   state | meaning
//   IDLE  | waiting for a word, ROM deselected
//   RUN   | issuing byte addresses and capturing ROM data
//   DONE  | out_valid held until the consumer accepts the word
module aes_sbox_rom_seq #(
  parameter int NBYTES  = 4,
  parameter int ROM_LAT = 1
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                flush,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic [8*NBYTES-1:0] in_data,
  input  logic                in_inv,
  output logic                out_valid,
  input  logic                out_ready,
  output logic [8*NBYTES-1:0] out_data,
  output logic                busy,
  output logic [8:0]          rom_addr,
  input  logic [7:0]          rom_data,
  output logic                rom_ce_n,
  output logic                rom_oe_n
);

  localparam int W  = 8 * NBYTES;
  localparam int PW = (NBYTES > 1) ? $clog2(NBYTES) : 1;
  localparam logic [PW-1:0] POS_TOP  = PW'(NBYTES - 1);
  localparam logic [PW-1:0] POS_NEXT = PW'((NBYTES > 1) ? NBYTES - 2 : 0);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t        state;
  logic [W-1:0]  word_q;
  logic          inv_q;
  logic [PW-1:0] issue_pos;
  logic          issue_more;
  logic          tag_v   [ROM_LAT];
  logic [PW-1:0] tag_pos [ROM_LAT];
  logic [7:0]    issue_byte;
  logic          accept;

  assign in_ready = (state == IDLE) && !flush;
  assign accept   = in_valid && in_ready;
  assign busy     = (state != IDLE);
  assign rom_oe_n = rom_ce_n;

  always_comb begin
    issue_byte = '0;
    for (int b = 0; b < NBYTES; b++)
      if (issue_pos == PW'(b)) issue_byte = word_q[8*b +: 8];
  end

  // Tag pipeline: each issued byte position travels ROM_LAT stages, so the head
  // names the byte whose ROM data is on rom_data at this edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      word_q     <= '0;
      inv_q      <= 1'b0;
      issue_pos  <= '0;
      issue_more <= 1'b0;
      out_data   <= '0;
      out_valid  <= 1'b0;
      rom_addr   <= '0;
      rom_ce_n   <= 1'b1;
      for (int i = 0; i < ROM_LAT; i++) begin
        tag_v[i]   <= 1'b0;
        tag_pos[i] <= '0;
      end
    end else begin
      for (int i = 1; i < ROM_LAT; i++) begin
        tag_v[i]   <= tag_v[i-1];
        tag_pos[i] <= tag_pos[i-1];
      end
      tag_v[0]   <= 1'b0;
      tag_pos[0] <= '0;

      if (flush) begin
        state      <= IDLE;
        out_valid  <= 1'b0;
        rom_ce_n   <= 1'b1;
        issue_more <= 1'b0;
        for (int i = 0; i < ROM_LAT; i++) tag_v[i] <= 1'b0;
      end else begin
        case (state)
          IDLE: begin
            if (accept) begin
              word_q     <= in_data;
              inv_q      <= in_inv;
              rom_addr   <= {in_inv, in_data[W-1 -: 8]};
              rom_ce_n   <= 1'b0;
              tag_v[0]   <= 1'b1;
              tag_pos[0] <= POS_TOP;
              issue_pos  <= POS_NEXT;
              issue_more <= (NBYTES > 1);
              state      <= RUN;
            end
          end
          RUN: begin
            if (issue_more) begin
              rom_addr   <= {inv_q, issue_byte};
              tag_v[0]   <= 1'b1;
              tag_pos[0] <= issue_pos;
              if (issue_pos == '0) issue_more <= 1'b0;
              else                 issue_pos  <= issue_pos - PW'(1);
            end
            if (tag_v[ROM_LAT-1]) begin
              for (int b = 0; b < NBYTES; b++)
                if (tag_pos[ROM_LAT-1] == PW'(b)) out_data[8*b +: 8] <= rom_data;
              if (tag_pos[ROM_LAT-1] == '0) begin
                out_valid <= 1'b1;
                rom_ce_n  <= 1'b1;
                state     <= DONE;
              end
            end
          end
          DONE: begin
            if (out_ready) begin
              out_valid <= 1'b0;
              state     <= IDLE;
            end
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_aes_sbox_rom_seq.sv
// Directed bench for aes_sbox_rom_seq: three instances (4/1, 4/3, 16/2) sharing one
// stimulus/observation path selected by g_sel, each with its own latency-accurate ROM.
module tb_aes_sbox_rom_seq;

  localparam logic [2047:0] SBOX_P = {
    128'h637c777bf26b6fc53001672bfed7ab76, 128'hca82c97dfa5947f0add4a2af9ca472c0,
    128'hb7fd9326363ff7cc34a5e5f171d83115, 128'h04c723c31896059a071280e2eb27b275,
    128'h09832c1a1b6e5aa0523bd6b329e32f84, 128'h53d100ed20fcb15b6acbbe394a4c58cf,
    128'hd0efaafb434d338545f9027f503c9fa8, 128'h51a3408f929d38f5bcb6da2110fff3d2,
    128'hcd0c13ec5f974417c4a77e3d645d1973, 128'h60814fdc222a908846eeb814de5e0bdb,
    128'he0323a0a4906245cc2d3ac629195e479, 128'he7c8376d8dd54ea96c56f4ea657aae08,
    128'hba78252e1ca6b4c6e8dd741f4bbd8b8a, 128'h703eb5664803f60e613557b986c11d9e,
    128'he1f8981169d98e949b1e87e9ce5528df, 128'h8ca1890dbfe6426841992d0fb054bb16};

  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic rst_n;

  int checks = 0;
  int failures = 0;

  logic [7:0] rom_tbl [512];
  initial begin
    logic [2047:0] bits;
    bits = SBOX_P;
    for (int i = 0; i < 256; i++) begin
      rom_tbl[i] = bits[2047-8*i -: 8];
      rom_tbl[256 + int'(bits[2047-8*i -: 8])] = 8'(i);
    end
  end

  int           g_sel;
  logic         g_in_valid, g_in_inv, g_flush, g_out_ready;
  logic [127:0] g_in_data;
  logic         g_in_ready, g_out_valid, g_busy, g_rom_ce_n, g_rom_oe_n;
  logic [127:0] g_out_data;
  logic [8:0]   g_rom_addr;

  logic d_sel, l3_sel, w_sel;
  assign d_sel  = (g_sel == 0);
  assign l3_sel = (g_sel == 1);
  assign w_sel  = (g_sel == 2);

  logic         d_in_ready, d_out_valid, d_busy, d_rom_ce_n, d_rom_oe_n;
  logic [31:0]  d_out_data;
  logic [8:0]   d_rom_addr;
  logic [7:0]   d_rom_data;
  logic         l3_in_ready, l3_out_valid, l3_busy, l3_rom_ce_n, l3_rom_oe_n;
  logic [31:0]  l3_out_data;
  logic [8:0]   l3_rom_addr;
  logic [7:0]   l3_rom_data, l3_p1, l3_p2;
  logic         w_in_ready, w_out_valid, w_busy, w_rom_ce_n, w_rom_oe_n;
  logic [127:0] w_out_data;
  logic [8:0]   w_rom_addr;
  logic [7:0]   w_rom_data, w_p1;

  // ROM models: ROM_LAT-1 register stages after the address
  assign d_rom_data  = rom_tbl[d_rom_addr];
  assign l3_rom_data = l3_p2;
  assign w_rom_data  = w_p1;
  always @(posedge clk) begin
    l3_p1 <= rom_tbl[l3_rom_addr];
    l3_p2 <= l3_p1;
    w_p1  <= rom_tbl[w_rom_addr];
  end

  aes_sbox_rom_seq #(.NBYTES(4), .ROM_LAT(1)) u_d (
    .clk(clk), .rst_n(rst_n), .flush(g_flush && d_sel), .in_valid(g_in_valid && d_sel),
    .in_ready(d_in_ready), .in_data(g_in_data[31:0]), .in_inv(g_in_inv),
    .out_valid(d_out_valid), .out_ready(g_out_ready), .out_data(d_out_data), .busy(d_busy),
    .rom_addr(d_rom_addr), .rom_data(d_rom_data), .rom_ce_n(d_rom_ce_n), .rom_oe_n(d_rom_oe_n));

  aes_sbox_rom_seq #(.NBYTES(4), .ROM_LAT(3)) u_l3 (
    .clk(clk), .rst_n(rst_n), .flush(g_flush && l3_sel), .in_valid(g_in_valid && l3_sel),
    .in_ready(l3_in_ready), .in_data(g_in_data[31:0]), .in_inv(g_in_inv),
    .out_valid(l3_out_valid), .out_ready(g_out_ready), .out_data(l3_out_data), .busy(l3_busy),
    .rom_addr(l3_rom_addr), .rom_data(l3_rom_data), .rom_ce_n(l3_rom_ce_n), .rom_oe_n(l3_rom_oe_n));

  aes_sbox_rom_seq #(.NBYTES(16), .ROM_LAT(2)) u_w (
    .clk(clk), .rst_n(rst_n), .flush(g_flush && w_sel), .in_valid(g_in_valid && w_sel),
    .in_ready(w_in_ready), .in_data(g_in_data), .in_inv(g_in_inv),
    .out_valid(w_out_valid), .out_ready(g_out_ready), .out_data(w_out_data), .busy(w_busy),
    .rom_addr(w_rom_addr), .rom_data(w_rom_data), .rom_ce_n(w_rom_ce_n), .rom_oe_n(w_rom_oe_n));

  always_comb begin
    g_in_ready  = d_in_ready;
    g_out_valid = d_out_valid;
    g_busy      = d_busy;
    g_rom_ce_n  = d_rom_ce_n;
    g_rom_oe_n  = d_rom_oe_n;
    g_out_data  = {96'b0, d_out_data};
    g_rom_addr  = d_rom_addr;
    case (g_sel)
      1: begin
        g_in_ready = l3_in_ready; g_out_valid = l3_out_valid; g_busy = l3_busy;
        g_rom_ce_n = l3_rom_ce_n; g_rom_oe_n = l3_rom_oe_n;
        g_out_data = {96'b0, l3_out_data}; g_rom_addr = l3_rom_addr;
      end
      2: begin
        g_in_ready = w_in_ready; g_out_valid = w_out_valid; g_busy = w_busy;
        g_rom_ce_n = w_rom_ce_n; g_rom_oe_n = w_rom_oe_n;
        g_out_data = w_out_data; g_rom_addr = w_rom_addr;
      end
      default: ;
    endcase
  end

  task automatic check_eq(input string tag, input logic [127:0] got, input logic [127:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Send one word with out_ready high; lat counts edges from accept to out_valid.
  task automatic run_word(input int sel, input logic [127:0] data, input logic inv,
                          output int lat, output int ce_low, output logic [35:0] seq,
                          output logic all_inv, output logic [127:0] res);
    g_sel = sel; g_in_data = data; g_in_inv = inv; g_in_valid = 1'b1; g_out_ready = 1'b1;
    @(posedge clk); #1;
    g_in_valid = 1'b0;
    lat = -1; ce_low = 0; seq = '0; all_inv = 1'b1; res = '0;
    for (int k = 0; k < 40; k++) begin
      if (!g_rom_ce_n) begin
        ce_low++;
        if (g_rom_addr[8] != inv) all_inv = 1'b0;
      end
      if (k < 4) seq = {seq[26:0], g_rom_addr};
      if (g_out_valid) begin
        lat = k;
        res = g_out_data;
        break;
      end
      @(posedge clk); #1;
    end
    @(posedge clk); #1;
  endtask

  int           lat, ce_low;
  logic [35:0]  seq;
  logic         all_inv, seen;
  logic [127:0] res, r1;

  localparam logic [127:0] WORD6 = 128'h00112233445566778899aabbccddeeff;

  initial begin
    g_sel = 0; g_in_valid = 0; g_in_inv = 0; g_flush = 0; g_out_ready = 1; g_in_data = '0;
    rst_n = 1'b0;
    #12;
    check_eq("rst_state", {g_out_data, g_out_valid, g_rom_addr, g_rom_ce_n, g_rom_oe_n, g_busy, g_in_ready},
             {128'h0, 1'b0, 9'h000, 1'b1, 1'b1, 1'b0, 1'b1});
    #10 rst_n = 1'b1;
    @(posedge clk); #1;

    // T1 forward
    run_word(0, 128'h000153ff, 1'b0, lat, ce_low, seq, all_inv, res);
    check_eq("t1_data", res, 128'h637ced16);
    check_eq("t1_lat", 128'(lat), 128'd4);
    check_eq("t1_ce_low", 128'(ce_low), 128'd4);
    check_eq("t1_addr_seq", 128'(seq), 128'({9'h000, 9'h001, 9'h053, 9'h0ff}));
    check_eq("t1_after_hs", {g_out_valid, g_in_ready, g_rom_oe_n}, 3'b011);

    // T2 inverse
    run_word(0, 128'h637ced16, 1'b1, lat, ce_low, seq, all_inv, res);
    check_eq("t2_data", res, 128'h000153ff);
    check_eq("t2_inv_bit", 128'(all_inv), 128'd1);
    check_eq("t2_addr_seq", 128'(seq), 128'({9'h163, 9'h17c, 9'h1ed, 9'h116}));

    // T3 ROM_LAT=3
    run_word(1, 128'h000153ff, 1'b0, lat, ce_low, seq, all_inv, res);
    check_eq("t3_data", res, 128'h637ced16);
    check_eq("t3_lat", 128'(lat), 128'd6);
    check_eq("t3_ce_low", 128'(ce_low), 128'd6);

    // T4 output backpressure with a second word waiting
    g_sel = 0; g_out_ready = 0; g_in_data = 128'h000153ff; g_in_inv = 0; g_in_valid = 1;
    @(posedge clk); #1;
    g_in_valid = 0;
    seen = 1'b0;
    for (int k = 0; k < 20; k++) begin
      if (g_out_valid) begin seen = 1'b1; break; end
      @(posedge clk); #1;
    end
    check_eq("t4_out_valid", 128'(seen), 128'd1);
    g_in_data = 128'h637ced16; g_in_inv = 1; g_in_valid = 1;
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      check_eq("t4_hold", {g_out_valid, g_in_ready, g_out_data[31:0]}, {1'b1, 1'b0, 32'h637ced16});
    end
    g_out_ready = 1;
    @(posedge clk); #1;
    check_eq("t4_hs", {g_out_valid, g_in_ready, g_busy}, 3'b010);
    @(posedge clk); #1;
    check_eq("t4_second_acc", 128'(g_busy), 128'd1);
    g_in_valid = 0;
    seen = 1'b0;
    for (int k = 0; k < 20; k++) begin
      if (g_out_valid) begin seen = 1'b1; break; end
      @(posedge clk); #1;
    end
    check_eq("t4_second_data", {seen, g_out_data[31:0]}, {1'b1, 32'h000153ff});
    @(posedge clk); #1;

    // T5 flush at A+2
    g_in_data = 128'h000153ff; g_in_inv = 0; g_in_valid = 1;
    @(posedge clk); #1;
    g_in_valid = 0;
    @(posedge clk); #1;
    g_flush = 1;
    @(posedge clk); #1;
    g_flush = 0;
    #1;
    check_eq("t5_flush", {g_out_valid, g_rom_ce_n, g_rom_oe_n, g_in_ready, g_busy}, 5'b01110);
    seen = 1'b0;
    for (int k = 0; k < 8; k++) begin
      @(posedge clk); #1;
      seen = seen | g_out_valid;
    end
    check_eq("t5_no_valid", 128'(seen), 128'd0);

    g_in_valid = 1; g_flush = 1;
    #1;
    check_eq("t5_flush_rdy", 128'(g_in_ready), 128'd0);
    @(posedge clk); #1;
    check_eq("t5_flush_wins", 128'(g_busy), 128'd0);
    g_in_valid = 0; g_flush = 0;
    @(posedge clk); #1;

    // T5 async reset at A+2
    g_in_data = 128'h000153ff; g_in_inv = 0; g_in_valid = 1;
    @(posedge clk); #1;
    g_in_valid = 0;
    @(posedge clk); #1;
    rst_n = 1'b0;
    #1;
    check_eq("t5_rst", {g_out_data, g_out_valid, g_rom_addr, g_rom_ce_n, g_rom_oe_n, g_busy},
             {128'h0, 1'b0, 9'h000, 1'b1, 1'b1, 1'b0});
    #2 rst_n = 1'b1;
    @(posedge clk); #1;
    run_word(0, 128'h000153ff, 1'b0, lat, ce_low, seq, all_inv, res);
    check_eq("t5_recover", res, 128'h637ced16);

    // T6 NBYTES=16, ROM_LAT=2 round trip
    run_word(2, WORD6, 1'b0, lat, ce_low, seq, all_inv, r1);
    check_eq("t6_fwd_data", r1, 128'h638293c31bfc33f5c4eeacea4bc12816);
    check_eq("t6_fwd_lat", 128'(lat), 128'd17);
    run_word(2, r1, 1'b1, lat, ce_low, seq, all_inv, res);
    check_eq("t6_inv_data", res, WORD6);
    check_eq("t6_inv_lat", 128'(lat), 128'd17);
    check_eq("t6_inv_bit", 128'(all_inv), 128'd1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end

endmodule
